rand_latency: RTL and testbench
===============================

# rand_latency

Handshake latency injector for the NPC simulation memory path. It accepts one request on a valid/ready interface and holds it for a computed number of cycles. It then presents a response that stays valid until the consumer takes it. It sits between the core-side request source and the fixed-latency delay stages. It adds a fixed or LFSR-randomised wait so that the core's handshakes are exercised under variable memory latency.

## Interface
- MIN_DELAY, 1: minimum wait cycles added after acceptance (>= 0).
- RAND_BITS, 3: number of LFSR bits added as random extra delay (1..8).
- SEED, 8'hA5: LFSR reset value; must be non-zero.
- clk  input  1  system clock; all state updates on posedge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  request present.
- in_ready  output  1  block can accept a request.
- rand_en  input  1  1: add random delay; 0: use MIN_DELAY only; sampled only at acceptance.
- out_valid  output  1  response present.
- out_ready  input  1  consumer takes the response.
- busy  output  1  high in WAIT or RESP.
- cur_delay  output  CNT_W  delay value latched at the last acceptance.

## Operation
- States: IDLE, WAIT, RESP (2-bit encoding).
- Reset values: state=IDLE, lfsr=SEED, cnt=0, cur_delay=0, in_ready=1, out_valid=0, busy=0.
- LFSR: 8-bit Fibonacci with polynomial x^8+x^6+x^5+x^4+1.
  - Shifts left every cycle in every state; the new bit0 is lfsr[7]^lfsr[5]^lfsr[4]^lfsr[3].
  - Never reaches 0 from a non-zero seed.
- Delay calculation: d = MIN_DELAY + (rand_en ? lfsr[RAND_BITS-1:0] : 0), using the lfsr value in the acceptance cycle.
  - CNT_W = $clog2(MIN_DELAY + 2**RAND_BITS) + 1, so there is no overflow.
- IDLE: in_ready=1. On in_valid: latch d into cnt and cur_delay.
  - d==0: go to RESP.
  - Otherwise: go to WAIT.
- WAIT: in_ready=0, out_valid=0. cnt decrements each cycle. When cnt==1 at a clock edge, go to RESP (cnt becomes 0).
- RESP: out_valid=1. On out_valid&&out_ready, go to IDLE.
  - out_valid must not drop until the handshake completes.
- in_ready and out_valid are decoded from state only.
  - No combinational path from in_valid or out_ready to any output.
- in_valid while not IDLE is ignored. Requests are not queued; the upstream must hold valid until in_ready.
- out_ready while not in RESP has no effect.
- Reset asserted mid-WAIT or mid-RESP: immediately returns to reset values. The pending response is dropped, with no out_valid glitch after release.

## Timing
- Acceptance edge T (in_valid && in_ready). First out_valid cycle is T+1+d.
  - d=0: out_valid in the cycle after acceptance.
  - MIN_DELAY=1, rand_en=0: out_valid 2 cycles after acceptance.
- Response handshake at edge R: in_ready=1 from cycle R+1. The next acceptance is no earlier than edge R+1.
- Maximum throughput is one request per d+2 cycles.
- busy equals (state != IDLE), registered along with state.
- cur_delay updates only at acceptance edges.

## Structure
- The shared npc utils package holds:
  - the state enum typedef (IDLE/WAIT/RESP);
  - the LFSR polynomial tap constant;
  - a function computing CNT_W from MIN_DELAY and RAND_BITS.
- Sub-module lfsr8 (clk, rst_n, SEED parameter, 8-bit q output, free-running). It is reused by other random-stall generators.
- The FSM and the down-counter stay in rand_latency.

## Test plan
- Reset, then rand_en=0, MIN_DELAY=1, in_valid=1 at cycle 0, out_ready=1.
  - Expect in_ready=1 at cycle 0, out_valid exactly at cycle 2, in_ready=1 at cycle 3, cur_delay=1.
- MIN_DELAY=0, rand_en=0.
  - Expect out_valid in the cycle after acceptance and busy=1 for exactly 1 cycle.
- rand_en=1, SEED=8'hA5, request at the first cycle after reset.
  - Expect d = 1 + (8'hA5 & 3'b111) = 6; out_valid at acceptance+7; cur_delay=6.
- Backpressure: hold out_ready=0 for 5 cycles once in RESP.
  - Expect out_valid stable high and in_ready=0 throughout; in_ready returns the cycle after out_ready=1.
- in_valid pulsed repeatedly while in WAIT.
  - Expect no change to cnt, cur_delay or latency, and exactly one response.
- Assert rst_n=0 mid-WAIT.
  - Expect immediate out_valid=0, in_ready=1, busy=0, lfsr=SEED; no response after release.

Source files
------------

// File: rtl/rand_latency_pkg.sv
// Shared types and helpers for the rand_latency latency injector and the
// random-stall generators that reuse the lfsr8 block.
package rand_latency_pkg;

   // Handshake FSM states
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } state_t;

   // Feedback taps for x^8+x^6+x^5+x^4+1: new bit0 = q[7]^q[5]^q[4]^q[3]
   localparam logic [7:0] LFSR_TAPS = 8'b1011_1000;

   // Counter width wide enough for MIN_DELAY plus the largest random term
   function automatic int cnt_width(input int min_delay, input int rand_bits);
      return $clog2(min_delay + (1 << rand_bits)) + 1;
   endfunction

   // Even parity of an 8-bit vector (used for LFSR feedback)
   function automatic logic parity8(input logic [7:0] v);
      return ^v;
   endfunction

endpackage

// File: rtl/rand_latency_if.sv
// Request/response handshake bundle between the request source (master)
// and the latency injector (slave).
interface rand_latency_if #(
   parameter int CNT_W = 5
);
   logic             in_valid;
   logic             in_ready;
   logic             rand_en;
   logic             out_valid;
   logic             out_ready;
   logic             busy;
   logic [CNT_W-1:0] cur_delay;

   modport master (
      output in_valid, rand_en, out_ready,
      input  in_ready, out_valid, busy, cur_delay
   );

   modport slave (
      input  in_valid, rand_en, out_ready,
      output in_ready, out_valid, busy, cur_delay
   );
endinterface

// File: rtl/lfsr8.sv
// Free-running 8-bit Fibonacci LFSR, x^8+x^6+x^5+x^4+1, shifting left.
// A zero state cannot be reached from a non-zero seed; should it ever occur
// (upset or bad seed) the register reloads SEED instead of locking up.
module lfsr8
   import rand_latency_pkg::*;
#(
   parameter logic [7:0] SEED = 8'hA5
) (
   input  logic       clk,
   input  logic       rst_n,
   output logic [7:0] q
);

   logic [7:0] lfsr_r;
   logic [7:0] lfsr_nxt_s;
   logic       fb_s;

   // Next LFSR value with lock-up recovery
   always_comb begin
      fb_s = parity8(lfsr_r & LFSR_TAPS);
      if (lfsr_r == 8'h00) begin
         lfsr_nxt_s = SEED;
      end else begin
         lfsr_nxt_s = {lfsr_r[6:0], fb_s};
      end
   end

   // LFSR state register, shifts every cycle
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         lfsr_r <= SEED;
      end else begin
         lfsr_r <= lfsr_nxt_s;
      end
   end

   assign q = lfsr_r;

endmodule

// File: rtl/rand_latency_chk.sv
// Protocol checker for the rand_latency handshake outputs.
module rand_latency_chk (
   input logic clk,
   input logic rst_n,
   input logic in_ready,
   input logic out_valid,
   input logic out_ready,
   input logic busy
);

   // A response that is not taken must still be presented next cycle
   a_resp_hold: assert property (@(posedge clk) disable iff (!rst_n)
      (out_valid && !out_ready) |=> out_valid);

   // Ready to accept exactly when not busy
   a_ready_busy: assert property (@(posedge clk) disable iff (!rst_n)
      in_ready == !busy);

   // Never ready for a request while presenting a response
   a_excl: assert property (@(posedge clk) disable iff (!rst_n)
      !(in_ready && out_valid));

endmodule

// File: rtl/rand_latency.sv
// Handshake latency injector: accepts one request, waits MIN_DELAY plus an
// optional LFSR-derived extra delay, then holds a response until taken.
// All outputs come straight from flops loaded with the next-state decode,
// so nothing combinational runs from in_valid/out_ready to an output.
module rand_latency
   import rand_latency_pkg::*;
#(
   parameter int         MIN_DELAY = 1,
   parameter int         RAND_BITS = 3,
   parameter logic [7:0] SEED      = 8'hA5,
   localparam int        CNT_W     = cnt_width(MIN_DELAY, RAND_BITS)
) (
   input  logic          clk,
   input  logic          rst_n,
   rand_latency_if.slave bus
);

   localparam logic [7:0] RAND_MASK = 8'((9'd1 << RAND_BITS) - 9'd1);

   state_t           state_r;
   state_t           state_nxt_s;
   logic [CNT_W-1:0] cnt_r;
   logic [CNT_W-1:0] cnt_nxt_s;
   logic [CNT_W-1:0] cur_delay_r;
   logic [CNT_W-1:0] cur_delay_nxt_s;
   logic [CNT_W-1:0] delay_s;
   logic [CNT_W-1:0] rand_term_s;
   logic [7:0]       lfsr_q_s;
   logic             in_ready_r;
   logic             out_valid_r;
   logic             busy_r;

   lfsr8 #(
      .SEED (SEED)
   ) u_lfsr (
      .clk   (clk),
      .rst_n (rst_n),
      .q     (lfsr_q_s)
   );

   // Delay that a request accepted in this cycle would receive
   always_comb begin
      rand_term_s = CNT_W'(lfsr_q_s & RAND_MASK);
      if (bus.rand_en) begin
         delay_s = CNT_W'(MIN_DELAY) + rand_term_s;
      end else begin
         delay_s = CNT_W'(MIN_DELAY);
      end
   end

   // Next-state and counter logic
   always_comb begin
      state_nxt_s     = state_r;
      cnt_nxt_s       = cnt_r;
      cur_delay_nxt_s = cur_delay_r;
      case (state_r)
         IDLE: begin
            if (bus.in_valid) begin
               cnt_nxt_s       = delay_s;
               cur_delay_nxt_s = delay_s;
               if (delay_s == '0) begin
                  state_nxt_s = RESP;
               end else begin
                  state_nxt_s = WAIT;
               end
            end else begin
               state_nxt_s = IDLE;
            end
         end
         WAIT: begin
            // cnt is never 0 here; treat 0 like 1 so a corrupted count exits
            if (cnt_r <= CNT_W'(1)) begin
               cnt_nxt_s   = '0;
               state_nxt_s = RESP;
            end else begin
               cnt_nxt_s   = cnt_r - CNT_W'(1);
               state_nxt_s = WAIT;
            end
         end
         RESP: begin
            if (out_valid_r && bus.out_ready) begin
               state_nxt_s = IDLE;
            end else begin
               state_nxt_s = RESP;
            end
         end
         default: begin
            state_nxt_s = IDLE;
            cnt_nxt_s   = '0;
         end
      endcase
   end

   // State, counter and registered output flops
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r     <= IDLE;
         cnt_r       <= '0;
         cur_delay_r <= '0;
         in_ready_r  <= 1'b1;
         out_valid_r <= 1'b0;
         busy_r      <= 1'b0;
      end else begin
         state_r     <= state_nxt_s;
         cnt_r       <= cnt_nxt_s;
         cur_delay_r <= cur_delay_nxt_s;
         in_ready_r  <= (state_nxt_s == IDLE);
         out_valid_r <= (state_nxt_s == RESP);
         busy_r      <= (state_nxt_s != IDLE);
      end
   end

   assign bus.in_ready  = in_ready_r;
   assign bus.out_valid = out_valid_r;
   assign bus.busy      = busy_r;
   assign bus.cur_delay = cur_delay_r;

endmodule

// File: tb/tb_rand_latency.sv
// Scoreboard bench for rand_latency: stimulus pushes the expected latency and
// cur_delay of every request; per-DUT monitors compare at each response.
module tb_rand_latency;
   import rand_latency_pkg::*;

   localparam int CW0 = cnt_width(1, 3);
   localparam int CW1 = cnt_width(0, 3);

   typedef struct {
      int lat;
      int dly;
   } exp_t;

   logic clk;
   logic rst_n;
   int   cyc;
   int   n_checks;
   int   n_err;
   exp_t q0[$];
   exp_t q1[$];
   int   exp_resp0, exp_resp1, resp0, resp1;
   int   acc0, acc1;
   logic prev_ov0, prev_ov1;

   rand_latency_if #(.CNT_W(CW0)) if0 ();
   rand_latency_if #(.CNT_W(CW1)) if1 ();

   rand_latency #(.MIN_DELAY(1), .RAND_BITS(3), .SEED(8'hA5)) u_dut0 (
      .clk (clk), .rst_n (rst_n), .bus (if0.slave));

   rand_latency #(.MIN_DELAY(0), .RAND_BITS(3), .SEED(8'hA5)) u_dut1 (
      .clk (clk), .rst_n (rst_n), .bus (if1.slave));

   rand_latency_chk u_chk0 (
      .clk (clk), .rst_n (rst_n), .in_ready (if0.in_ready),
      .out_valid (if0.out_valid), .out_ready (if0.out_ready), .busy (if0.busy));

   rand_latency_chk u_chk1 (
      .clk (clk), .rst_n (rst_n), .in_ready (if1.in_ready),
      .out_valid (if1.out_valid), .out_ready (if1.out_ready), .busy (if1.busy));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input int act, input int exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_idle0(input string name, input int max);
      for (int k = 0; k < max; k++) begin
         if (if0.in_ready) break;
         tick();
      end
      chk(name, int'(if0.in_ready), 1);
   endtask

   // Monitor DUT0: record acceptance, compare each new response
   always @(negedge clk) begin
      if (!rst_n) begin
         prev_ov0 = 1'b0;
      end else begin
         if (if0.in_valid && if0.in_ready) acc0 = cyc;
         if (if0.out_valid && !prev_ov0) begin
            resp0++;
            if (q0.size() == 0) begin
               chk("dut0_unexpected_resp", 1, 0);
            end else begin
               exp_t e;
               e = q0.pop_front();
               chk("dut0_latency", cyc - acc0, e.lat);
               chk("dut0_cur_delay", int'(if0.cur_delay), e.dly);
            end
         end
         prev_ov0 = if0.out_valid;
      end
   end

   // Monitor DUT1: record acceptance, compare each new response
   always @(negedge clk) begin
      if (!rst_n) begin
         prev_ov1 = 1'b0;
      end else begin
         if (if1.in_valid && if1.in_ready) acc1 = cyc;
         if (if1.out_valid && !prev_ov1) begin
            resp1++;
            if (q1.size() == 0) begin
               chk("dut1_unexpected_resp", 1, 0);
            end else begin
               exp_t e;
               e = q1.pop_front();
               chk("dut1_latency", cyc - acc1, e.lat);
               chk("dut1_cur_delay", int'(if1.cur_delay), e.dly);
            end
         end
         prev_ov1 = if1.out_valid;
      end
   end

   // Watchdog
   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      cyc = 0; n_checks = 0; n_err = 0;
      exp_resp0 = 0; exp_resp1 = 0; resp0 = 0; resp1 = 0;
      acc0 = 0; acc1 = 0;
      rst_n = 1'b0;
      if0.in_valid = 1'b0; if0.rand_en = 1'b0; if0.out_ready = 1'b1;
      if1.in_valid = 1'b0; if1.rand_en = 1'b0; if1.out_ready = 1'b1;
      tick(); tick();

      // Reset state
      chk("rst_in_ready0", int'(if0.in_ready), 1);
      chk("rst_out_valid0", int'(if0.out_valid), 0);
      chk("rst_busy0", int'(if0.busy), 0);
      chk("rst_cur_delay0", int'(if0.cur_delay), 0);
      chk("rst_in_ready1", int'(if1.in_ready), 1);
      chk("rst_busy1", int'(if1.busy), 0);

      // Random delay at first cycle after reset: d = 1 + (A5 & 7) = 6
      if0.in_valid = 1'b1; if0.rand_en = 1'b1;
      q0.push_back('{lat: 7, dly: 6}); exp_resp0++;
      rst_n = 1'b1;
      tick();
      if0.in_valid = 1'b0; if0.rand_en = 1'b0;
      chk("rand_cur_delay", int'(if0.cur_delay), 6);
      chk("rand_busy", int'(if0.busy), 1);
      wait_idle0("rand_done_timeout", 40);
      tick();

      // Fixed MIN_DELAY=1: out_valid at cycle 2, in_ready back at cycle 3
      if0.in_valid = 1'b1; if0.rand_en = 1'b0;
      chk("fix_in_ready_c0", int'(if0.in_ready), 1);
      q0.push_back('{lat: 2, dly: 1}); exp_resp0++;
      tick();
      if0.in_valid = 1'b0;
      chk("fix_out_valid_c1", int'(if0.out_valid), 0);
      tick();
      chk("fix_out_valid_c2", int'(if0.out_valid), 1);
      tick();
      chk("fix_in_ready_c3", int'(if0.in_ready), 1);
      chk("fix_cur_delay", int'(if0.cur_delay), 1);

      // Backpressure: out_ready low for 5 cycles in RESP
      if0.out_ready = 1'b0; if0.in_valid = 1'b1;
      q0.push_back('{lat: 2, dly: 1}); exp_resp0++;
      tick();
      if0.in_valid = 1'b0;
      tick();
      for (int i = 0; i < 5; i++) begin
         chk("bp_out_valid_hold", int'(if0.out_valid), 1);
         chk("bp_in_ready_low", int'(if0.in_ready), 0);
         tick();
      end
      if0.out_ready = 1'b1;
      chk("bp_out_valid_last", int'(if0.out_valid), 1);
      tick();
      chk("bp_in_ready_back", int'(if0.in_ready), 1);
      chk("bp_out_valid_drop", int'(if0.out_valid), 0);

      // MIN_DELAY=0: response next cycle, busy for one cycle
      if1.in_valid = 1'b1;
      chk("d0_in_ready_c0", int'(if1.in_ready), 1);
      q1.push_back('{lat: 1, dly: 0}); exp_resp1++;
      tick();
      if1.in_valid = 1'b0;
      chk("d0_out_valid_c1", int'(if1.out_valid), 1);
      chk("d0_busy_c1", int'(if1.busy), 1);
      tick();
      chk("d0_busy_c2", int'(if1.busy), 0);
      chk("d0_in_ready_c2", int'(if1.in_ready), 1);

      // Reset mid-WAIT drops the pending request
      if0.in_valid = 1'b1; if0.rand_en = 1'b0;
      tick();
      if0.in_valid = 1'b0;
      chk("mw_busy_pre", int'(if0.busy), 1);
      rst_n = 1'b0;
      #1;
      chk("mw_out_valid", int'(if0.out_valid), 0);
      chk("mw_in_ready", int'(if0.in_ready), 1);
      chk("mw_busy", int'(if0.busy), 0);
      chk("mw_cur_delay", int'(if0.cur_delay), 0);

      // After release the LFSR is back at SEED: d = 6 again
      if0.in_valid = 1'b1; if0.rand_en = 1'b1;
      q0.push_back('{lat: 7, dly: 6}); exp_resp0++;
      tick();
      rst_n = 1'b1;
      tick();
      // in_valid pulsed during WAIT must be ignored
      for (int i = 0; i < 4; i++) begin
         if0.in_valid = (i % 2 == 0);
         if0.rand_en = 1'b0;
         chk("pulse_cur_delay", int'(if0.cur_delay), 6);
         chk("pulse_in_ready", int'(if0.in_ready), 0);
         tick();
      end
      if0.in_valid = 1'b0;
      wait_idle0("pulse_done_timeout", 40);
      for (int i = 0; i < 6; i++) tick();

      chk("q0_empty", q0.size(), 0);
      chk("q1_empty", q1.size(), 0);
      chk("resp0_count", resp0, exp_resp0);
      chk("resp1_count", resp1, exp_resp1);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $finish;
   end

endmodule
